// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared JK excitation encoding and counter defaults
package jk_pkg;

   // {J,K} pairs as seen by a jk_cell on each edge
   typedef enum logic [1:0] {
      HOLD = 2'b00,
      RST  = 2'b01,
      SET  = 2'b10,
      TGL  = 2'b11
   } jk_op_e;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_MODULUS = 10;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high clear
module jk_cell
   import jk_pkg::*;
(
   input  logic J,
   input  logic K,
   input  logic clk,
   input  logic clear,
   output logic Q,
   output logic Qbar
);

   always_ff @(posedge clk) begin
      if (clear) begin
         Q <= 1'b0;
      end else begin
         case ({J, K})
            HOLD:    Q <= Q;
            RST:     Q <= 1'b0;
            SET:     Q <= 1'b1;
            TGL:     Q <= ~Q;
            default: Q <= Q;
         endcase
      end
   end

   assign Qbar = ~Q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - up/down modulo counter with parallel load built from JK cells
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int MODULUS = DEF_MODULUS
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] d_clamped;
   logic [WIDTH-1:0] next_up;
   logic [WIDTH-1:0] next_dn;
   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (Q == MAX_VAL);
   assign at_zero = (Q == '0);

   // Toggle mask is the set of bits that differ between Q and its successor
   always_comb begin
      next_up   = at_max  ? '0      : Q + 1'b1;
      next_dn   = at_zero ? MAX_VAL : Q - 1'b1;
      toggle    = Q ^ (up ? next_up : next_dn);
      d_clamped = (32'(din) >= MODULUS) ? MAX_VAL : din;
   end

   assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         assign j[i] = load ? d_clamped[i]  : (en & toggle[i]);
         assign k[i] = load ? ~d_clamped[i] : (en & toggle[i]);

         jk_cell u_cell (
            .J     (j[i]),
            .K     (k[i]),
            .clk   (clk),
            .clear (clear),
            .Q     (Q[i]),
            .Qbar  (Qbar[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (clear) begin
         wrap <= 1'b0;
      end else begin
         wrap <= tc;
      end
   end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - scoreboard bench for jk_mod_counter against an arithmetic model
module tb_jk_mod_counter;

   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         clear;
   logic         en;
   logic         up;
   logic         load;
   logic [W-1:0] din;
   logic [W-1:0] Q;
   logic [W-1:0] Qbar;
   logic         tc;
   logic         wrap;

   jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
      .clk   (clk),
      .clear (clear),
      .en    (en),
      .up    (up),
      .load  (load),
      .din   (din),
      .Q     (Q),
      .Qbar  (Qbar),
      .tc    (tc),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         chk_tc;
      bit         tc;
      bit         chk_q;
      bit [W-1:0] q;
      bit         wrap;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   bit   stim_done = 0;
   int   m_q       = 0;
   bit   m_known   = 0;
   int   idle      = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit c, input bit e, input bit u, input bit l, input int d);
      exp_t x;
      int   nq;
      bit   t;
      @(negedge clk);
      clear = c;
      en    = e;
      up    = u;
      load  = l;
      din   = W'(d);
      t = e && !l && ((u && m_q == M - 1) || (!u && m_q == 0));
      if (c)
         nq = 0;
      else if (l)
         nq = (d >= M) ? M - 1 : d;
      else if (e)
         nq = u ? (m_q + 1) % M : (m_q + M - 1) % M;
      else
         nq = m_q;
      x.chk_tc = m_known;
      x.tc     = t;
      x.chk_q  = m_known || c || l;
      x.q      = W'(nq);
      x.wrap   = !c && t;
      m_known  = m_known || c || l;
      m_q      = nq;
      sb.push_back(x);
   endtask

   initial begin
      clear = 1'b1;
      en    = 1'b0;
      up    = 1'b0;
      load  = 1'b0;
      din   = '0;

      repeat (5) step(1, 1, 0, 1, 5);
      repeat (12) step(0, 1, 1, 0, 0);
      repeat (4) step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 7);
      step(0, 0, 0, 1, 13);
      step(0, 1, 1, 1, 3);
      repeat (2) step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(0, 0, 0, 1, 4);
      for (int i = 0; i < 4; i++) step(0, 1, (i % 2) == 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(29) == 0, $urandom_range(3) != 0, 1'($urandom),
              $urandom_range(7) == 0, int'($urandom_range(15)));
      end
      stim_done = 1'b1;
   end

   initial begin
      exp_t         x;
      bit [W-1:0]   nb;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() == 0) begin
            if (stim_done) break;
            idle++;
            if (idle > 20) begin
               chk("scoreboard_timeout", idle, 0);
               break;
            end
            continue;
         end
         idle = 0;
         x = sb.pop_front();
         if (x.chk_tc) chk("tc", int'(tc), int'(x.tc));
         @(posedge clk);
         #1;
         if (x.chk_q) begin
            nb = ~x.q;
            chk("Q", int'(Q), int'(x.q));
            chk("Qbar", int'(Qbar), int'(nb));
            chk("wrap", int'(wrap), int'(x.wrap));
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
